// File: rtl/forward_ctrl_pkg.sv
// forward_ctrl_pkg: shared encodings for the operand-forwarding controller.
//   fwd_sel_e  : EX operand mux select (regfile / EX-MEM result / MEM-WB result)
//   fc_state_e : load-use FSM states
package forward_ctrl_pkg;

  localparam int REG_AW_DEF = 5;    // RegAddrBus width
  localparam int ZERO_REG_DEF = 31; // XZR, never forwarded

  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    S_RUN    = 1'b0,
    S_BUBBLE = 1'b1
  } fc_state_e;

endpackage

// File: rtl/forward_ctrl_match.sv
// fwd_match: combinational producer match for one source operand.
//   src/used             : source register address and whether it is read
//   ex_*                 : tracking slot for the instruction in EX
//   mem_*                : tracking slot for the instruction in MEM
//   sel                  : forwarding select (EX slot beats MEM slot)
//   load_hit             : EX-slot producer is a load (load-use hazard source)
module fwd_match
  import forward_ctrl_pkg::*;
#(
  parameter int REG_AW   = REG_AW_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF
) (
  input  logic [REG_AW-1:0] src,
  input  logic              used,
  input  logic              ex_vld,
  input  logic              ex_wreg,
  input  logic              ex_load,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              mem_vld,
  input  logic              mem_wreg,
  input  logic [REG_AW-1:0] mem_rd,
  output fwd_sel_e          sel,
  output logic              load_hit
);
  logic live, ex_hit, mem_hit;

  assign live    = used && (src != REG_AW'(ZERO_REG));
  assign ex_hit  = live && ex_vld && ex_wreg && (ex_rd == src);
  assign mem_hit = live && mem_vld && mem_wreg && (mem_rd == src);

  // EX slot holds the younger producer, so it takes priority.
  always_comb begin
    sel = FWD_REG;
    if (ex_hit)       sel = FWD_EXMEM;
    else if (mem_hit) sel = FWD_MEMWB;
  end

  assign load_hit = ex_hit && ex_load;
endmodule

// File: rtl/forward_ctrl.sv
// forward_ctrl: operand-forwarding and load-use hazard control for the
// 5-stage integer pipeline.
//   clk, rst            : clock, synchronous active-high reset
//   hold_i              : freeze everything (memory wait)
//   flush_i             : squash the instruction in ID
//   id_*                : decoded fields of the instruction in ID
//   fwd_a_sel_o/b_sel_o : registered EX operand mux selects
//   stall_o             : combinational load-use stall request
//   ex_slot_valid_o     : EX tracking slot occupied
module forward_ctrl
  import forward_ctrl_pkg::*;
#(
  parameter int REG_AW   = REG_AW_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold_i,
  input  logic              flush_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rn_i,
  input  logic [REG_AW-1:0] id_rm_i,
  input  logic              id_rn_used_i,
  input  logic              id_rm_used_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_wreg_i,
  input  logic              id_load_i,
  output logic [1:0]        fwd_a_sel_o,
  output logic [1:0]        fwd_b_sel_o,
  output logic              stall_o,
  output logic              ex_slot_valid_o
);
  logic              ex_vld, ex_wreg, ex_load;
  logic [REG_AW-1:0] ex_rd;
  logic              mem_vld, mem_wreg;
  logic [REG_AW-1:0] mem_rd;

  fc_state_e state, state_nx;

  logic [1:0][REG_AW-1:0] src;
  logic [1:0]             used, ld_hit;
  fwd_sel_e               sel [2];
  logic                   id_live, hazard;

  assign id_live = id_valid_i && !flush_i;
  assign src     = {id_rm_i, id_rn_i};
  assign used    = {id_rm_used_i, id_rn_used_i};

  // Index 0 = Rn (operand A), index 1 = Rm (operand B).
  for (genvar g = 0; g < 2; g++) begin : g_src
    fwd_match #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_match (
      .src      (src[g]),
      .used     (used[g]),
      .ex_vld   (ex_vld),
      .ex_wreg  (ex_wreg),
      .ex_load  (ex_load),
      .ex_rd    (ex_rd),
      .mem_vld  (mem_vld),
      .mem_wreg (mem_wreg),
      .mem_rd   (mem_rd),
      .sel      (sel[g]),
      .load_hit (ld_hit[g])
    );
  end

  // Both operands hitting the same load still give a single stall; flush
  // removes the consumer so there is nothing to protect.
  assign hazard  = (state == S_RUN) && id_live && (|ld_hit);
  assign stall_o = hazard && !hold_i;

  always_comb begin
    state_nx = state;
    if (!hold_i) begin
      case (state)
        S_RUN:    if (hazard) state_nx = S_BUBBLE;
        S_BUBBLE: state_nx = S_RUN;
        default:  state_nx = S_RUN;
      endcase
    end
  end

  // On a stall the load moves on to MEM and a bubble enters EX; during the
  // BUBBLE cycle the held consumer re-evaluates and finds the load in MEM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RUN;
      ex_vld      <= 1'b0;
      ex_wreg     <= 1'b0;
      ex_load     <= 1'b0;
      ex_rd       <= '0;
      mem_vld     <= 1'b0;
      mem_wreg    <= 1'b0;
      mem_rd      <= '0;
      fwd_a_sel_o <= FWD_REG;
      fwd_b_sel_o <= FWD_REG;
    end else if (!hold_i) begin
      state    <= state_nx;
      mem_vld  <= ex_vld;
      mem_wreg <= ex_wreg;
      mem_rd   <= ex_rd;
      if (stall_o) begin
        ex_vld      <= 1'b0;
        ex_wreg     <= 1'b0;
        ex_load     <= 1'b0;
        fwd_a_sel_o <= FWD_REG;
        fwd_b_sel_o <= FWD_REG;
      end else begin
        ex_vld      <= id_live;
        ex_wreg     <= id_wreg_i;
        ex_load     <= id_load_i;
        ex_rd       <= id_rd_i;
        fwd_a_sel_o <= id_live ? sel[0] : FWD_REG;
        fwd_b_sel_o <= id_live ? sel[1] : FWD_REG;
      end
    end
  end

  assign ex_slot_valid_o = ex_vld;
endmodule

// File: tb/tb_forward_ctrl.sv
// Scoreboard bench for forward_ctrl. The reference model keeps a two-deep
// queue of the instructions ahead of ID (front = EX, back = MEM) and derives
// selects and stalls from the forwarding rules directly.
module tb_forward_ctrl;
  logic       clk = 1'b0;
  logic       rst, hold_i, flush_i, id_valid_i;
  logic [4:0] id_rn_i, id_rm_i, id_rd_i;
  logic       id_rn_used_i, id_rm_used_i, id_wreg_i, id_load_i;
  logic [1:0] fwd_a_sel_o, fwd_b_sel_o;
  logic       stall_o, ex_slot_valid_o;

  always #5 clk = ~clk;

  forward_ctrl #(.REG_AW(5), .ZERO_REG(31)) dut (
    .clk(clk), .rst(rst), .hold_i(hold_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_rn_i(id_rn_i), .id_rm_i(id_rm_i),
    .id_rn_used_i(id_rn_used_i), .id_rm_used_i(id_rm_used_i),
    .id_rd_i(id_rd_i), .id_wreg_i(id_wreg_i), .id_load_i(id_load_i),
    .fwd_a_sel_o(fwd_a_sel_o), .fwd_b_sel_o(fwd_b_sel_o),
    .stall_o(stall_o), .ex_slot_valid_o(ex_slot_valid_o)
  );

  typedef struct { bit vld; int rd; bit wreg; bit load; } slot_t;
  typedef struct { logic stall; logic [1:0] a; logic [1:0] b; logic exv; } exp_t;

  slot_t pipe[$];        // [0] = instruction in EX, [1] = instruction in MEM
  int    m_a, m_b;       // selects currently presented to EX
  exp_t  sb[$];
  int    checks = 0, errors = 0;
  bit    done = 0;

  function automatic bit writes(slot_t s, int src, bit used);
    return s.vld && s.wreg && used && src != 31 && s.rd == src;
  endfunction

  function automatic int pick(int src, bit used);
    if (writes(pipe[0], src, used)) return 1;
    if (writes(pipe[1], src, used)) return 2;
    return 0;
  endfunction

  function automatic void model_reset();
    slot_t z;
    z = '{vld: 0, rd: 0, wreg: 0, load: 0};
    pipe = {z, z};
    m_a = 0;
    m_b = 0;
  endfunction

  bit last_stall;

  // One ID cycle: drive inputs, queue what the outputs must show in this
  // cycle, then advance the model as the next edge will.
  task automatic drive(input bit r, h, f, v, input int rn, rm, input bit rnu, rmu,
                       input int rd, input bit w, l, input bit chk);
    exp_t  e;
    slot_t s;
    bit    live, stl;
    rst = r; hold_i = h; flush_i = f; id_valid_i = v;
    id_rn_i = 5'(rn); id_rm_i = 5'(rm); id_rn_used_i = rnu; id_rm_used_i = rmu;
    id_rd_i = 5'(rd); id_wreg_i = w; id_load_i = l;
    live = v && !f;
    stl  = !h && live && pipe[0].load &&
           (writes(pipe[0], rn, rnu) || writes(pipe[0], rm, rmu));
    e.stall = stl; e.a = 2'(m_a); e.b = 2'(m_b); e.exv = pipe[0].vld;
    if (chk) sb.push_back(e);
    last_stall = stl;
    if (r) model_reset();
    else if (!h) begin
      if (stl) begin
        s = '{vld: 0, rd: 0, wreg: 0, load: 0};
        m_a = 0; m_b = 0;
      end else begin
        s = '{vld: live, rd: rd, wreg: w, load: l};
        m_a = live ? pick(rn, rnu) : 0;
        m_b = live ? pick(rm, rmu) : 0;
      end
      pipe.push_front(s);
      void'(pipe.pop_back());
    end
    @(posedge clk); #1;
  endtask

  // Monitor: every cycle the DUT presents outputs; compare against the queue.
  initial begin
    exp_t e;
    while (!done || sb.size() != 0) begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks += 4;
        if (stall_o !== e.stall) begin
          errors++; $display("FAIL stall_o got %b want %b @%0t", stall_o, e.stall, $time);
        end
        if (fwd_a_sel_o !== e.a) begin
          errors++; $display("FAIL fwd_a_sel got %b want %b @%0t", fwd_a_sel_o, e.a, $time);
        end
        if (fwd_b_sel_o !== e.b) begin
          errors++; $display("FAIL fwd_b_sel got %b want %b @%0t", fwd_b_sel_o, e.b, $time);
        end
        if (ex_slot_valid_o !== e.exv) begin
          errors++; $display("FAIL ex_slot_valid got %b want %b @%0t", ex_slot_valid_o, e.exv, $time);
        end
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  function automatic int rreg();
    int t;
    t = $urandom_range(0, 4);
    return (t == 4) ? 31 : t + 1;
  endfunction

  initial begin
    int rn, rm, rd;
    bit rnu, rmu, w, l, v;
    model_reset();
    @(posedge clk); #1;
    // reset: first cycle outputs are undefined, the next one must be clean
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // ADD X1,X2,X3 ; SUB X4,X1,X5 -> A=01
    drive(0, 0, 0, 1, 2, 3, 1, 1, 1, 1, 0, 1);
    drive(0, 0, 0, 1, 1, 5, 1, 1, 4, 1, 0, 1);
    // ADD X1 ; NOP ; ORR X6,X7,X1 -> B=10
    drive(0, 0, 0, 1, 2, 3, 1, 1, 1, 1, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 1, 7, 1, 1, 1, 6, 1, 0, 1);
    // ADD X1 ; ADD X1 ; use X1 -> 01
    drive(0, 0, 0, 1, 2, 3, 1, 1, 1, 1, 0, 1);
    drive(0, 0, 0, 1, 2, 3, 1, 1, 1, 1, 0, 1);
    drive(0, 0, 0, 1, 1, 1, 1, 1, 8, 1, 0, 1);
    // LDR X9 ; ADD X3,X9,X9 (stalled once, then 10/10)
    drive(0, 0, 0, 1, 2, 0, 1, 0, 9, 1, 1, 1);
    drive(0, 0, 0, 1, 9, 9, 1, 1, 3, 1, 0, 1);
    drive(0, 0, 0, 1, 9, 9, 1, 1, 3, 1, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // XZR producer/consumer, unused matching source
    drive(0, 0, 0, 1, 2, 3, 1, 1, 31, 1, 0, 1);
    drive(0, 0, 0, 1, 31, 31, 1, 1, 4, 1, 0, 1);
    drive(0, 0, 0, 1, 4, 4, 0, 1, 5, 1, 0, 1);
    // LDR X9 ; dependent ADD flushed ; follower reading X3
    drive(0, 0, 0, 1, 2, 0, 1, 0, 9, 1, 1, 1);
    drive(0, 0, 1, 1, 9, 9, 1, 1, 3, 1, 0, 1);
    drive(0, 0, 0, 1, 3, 9, 1, 1, 6, 1, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // hold three cycles mid-stream
    drive(0, 0, 0, 1, 2, 3, 1, 1, 1, 1, 0, 1);
    drive(0, 1, 0, 1, 1, 1, 1, 1, 2, 1, 0, 1);
    drive(0, 1, 0, 1, 1, 1, 1, 1, 2, 1, 0, 1);
    drive(0, 1, 0, 1, 1, 1, 1, 1, 2, 1, 0, 1);
    drive(0, 0, 0, 1, 1, 1, 1, 1, 2, 1, 0, 1);
    // reset during the bubble cycle
    drive(0, 0, 0, 1, 2, 0, 1, 0, 9, 1, 1, 1);
    drive(0, 0, 0, 1, 9, 9, 1, 1, 3, 1, 0, 1);
    drive(1, 0, 0, 1, 9, 9, 1, 1, 3, 1, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // randomized traffic; a stalled instruction is re-presented in ID
    rn = 0; rm = 0; rd = 0; rnu = 0; rmu = 0; w = 0; l = 0; v = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!last_stall) begin
        v   = ($urandom_range(0, 99) < 85);
        rn  = rreg(); rm = rreg(); rd = rreg();
        rnu = ($urandom_range(0, 99) < 80);
        rmu = ($urandom_range(0, 99) < 80);
        w   = ($urandom_range(0, 99) < 85);
        l   = ($urandom_range(0, 99) < 35);
      end
      drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 15),
            ($urandom_range(0, 99) < 10), v, rn, rm, rnu, rmu, rd, w, l, 1);
    end
    done = 1;
  end
endmodule
